// File: rtl/out_writeback.sv
`default_nettype none
// ============================================================================
// Module   : out_writeback
// Brief    : Drains PE-array result rows after a tile flush into the output
//            SRAM, one row per SRAM row, with row suppression and bit enables.
//            Optional macro OUT_WRITEBACK_RELU_EN clamps negative lanes to 0.
// Revision : 1.0 - initial release
// ============================================================================
module out_writeback #(
    parameter int ACC_BWIDTH             = 32,
    parameter int PE_ARRAY_NUM_ROWS      = 32,
    parameter int PE_ARRAY_NUM_ROWS_LOG2 = 5,
    parameter int PE_ARRAY_NUM_COLS      = 32,
    parameter int PE_ARRAY_NUM_COLS_LOG2 = 5,
    parameter int OUT_SRAM_AWIDTH        = 10,
    parameter int OUT_SRAM_BWIDTH        = 32*32
) (
    input  logic                              CLK,
    input  logic                              RSTn,
    input  logic                              STALL,
    input  logic                              FLUSH_START_in,
    input  logic [OUT_SRAM_AWIDTH-1:0]        TILE_BASE_ADDR_in,
    input  logic [PE_ARRAY_NUM_ROWS_LOG2:0]   VALID_ROWS_in,
    input  logic [PE_ARRAY_NUM_COLS_LOG2:0]   VALID_COLS_in,
    input  logic                              ROW_VALID_in,
    input  logic [OUT_SRAM_BWIDTH-1:0]        ROW_DATA_in,
    output logic                              ROW_READY_out,
    output logic [OUT_SRAM_AWIDTH-1:0]        OUT_SRAM_ADDR_out,
    output logic                              OUT_SRAM_WEn_out,
    output logic [OUT_SRAM_BWIDTH-1:0]        OUT_SRAM_BE_out,
    output logic [OUT_SRAM_BWIDTH-1:0]        OUT_SRAM_D_out,
    output logic                              BUSY_out,
    output logic                              DONE_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRAIN  = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [PE_ARRAY_NUM_ROWS_LOG2:0]   c_rows_max =
        (PE_ARRAY_NUM_ROWS_LOG2+1)'(PE_ARRAY_NUM_ROWS);
    localparam logic [PE_ARRAY_NUM_COLS_LOG2:0]   c_cols_max =
        (PE_ARRAY_NUM_COLS_LOG2+1)'(PE_ARRAY_NUM_COLS);
    localparam logic [PE_ARRAY_NUM_ROWS_LOG2-1:0] c_last_row =
        PE_ARRAY_NUM_ROWS_LOG2'(PE_ARRAY_NUM_ROWS-1);

    state_t                              r_state;
    logic [PE_ARRAY_NUM_ROWS_LOG2-1:0]   r_row_cnt;
    logic [OUT_SRAM_AWIDTH-1:0]          r_base;
    logic [PE_ARRAY_NUM_ROWS_LOG2:0]     r_vrows;
    logic [PE_ARRAY_NUM_COLS_LOG2:0]     r_vcols;
    logic [OUT_SRAM_AWIDTH-1:0]          r_addr;
    logic                                r_wen;
    logic [OUT_SRAM_BWIDTH-1:0]          r_be;
    logic [OUT_SRAM_BWIDTH-1:0]          r_d;
    logic                                r_busy;
    logic                                r_done;

    logic [PE_ARRAY_NUM_ROWS_LOG2:0]     w_vrows_sat;
    logic [PE_ARRAY_NUM_COLS_LOG2:0]     w_vcols_sat;
    logic [OUT_SRAM_AWIDTH-1:0]          w_row_addr;
    logic                                w_row_wr;
    logic [OUT_SRAM_BWIDTH-1:0]          w_be;
    logic [OUT_SRAM_BWIDTH-1:0]          w_d;

    assign w_vrows_sat = (VALID_ROWS_in > c_rows_max) ? c_rows_max : VALID_ROWS_in;
    assign w_vcols_sat = (VALID_COLS_in > c_cols_max) ? c_cols_max : VALID_COLS_in;

    // Address arithmetic deliberately wraps at the SRAM address width.
    assign w_row_addr = r_base + OUT_SRAM_AWIDTH'(r_row_cnt);
    assign w_row_wr   = ({1'b0, r_row_cnt} < r_vrows);

    // Column 0 occupies the most significant lane.
    for (genvar c = 0; c < PE_ARRAY_NUM_COLS; c++) begin : g_col_be
        localparam logic [PE_ARRAY_NUM_COLS_LOG2:0] c_col = (PE_ARRAY_NUM_COLS_LOG2+1)'(c);
        assign w_be[(PE_ARRAY_NUM_COLS-1-c)*ACC_BWIDTH +: ACC_BWIDTH] =
            {ACC_BWIDTH{(c_col < r_vcols)}};
    end

`ifdef OUT_WRITEBACK_RELU_EN
    for (genvar c = 0; c < PE_ARRAY_NUM_COLS; c++) begin : g_relu
        assign w_d[c*ACC_BWIDTH +: ACC_BWIDTH] =
            ROW_DATA_in[c*ACC_BWIDTH + ACC_BWIDTH - 1] ? '0 :
            ROW_DATA_in[c*ACC_BWIDTH +: ACC_BWIDTH];
    end
`else
    assign w_d = ROW_DATA_in;
`endif

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state   <= S_IDLE;
            r_row_cnt <= '0;
            r_base    <= '0;
            r_vrows   <= '0;
            r_vcols   <= '0;
            r_addr    <= '0;
            r_wen     <= 1'b1;
            r_be      <= '0;
            r_d       <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else if (!STALL) begin
            r_wen  <= 1'b1;
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // r_done still high means this is the DONE cycle: ignore start.
                    if (FLUSH_START_in && !r_done) begin
                        r_state   <= S_DRAIN;
                        r_base    <= TILE_BASE_ADDR_in;
                        r_vrows   <= w_vrows_sat;
                        r_vcols   <= w_vcols_sat;
                        r_row_cnt <= '0;
                        r_busy    <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (ROW_VALID_in) begin
                        r_d       <= w_d;
                        r_addr    <= w_row_addr;
                        r_be      <= w_be;
                        r_wen     <= ~w_row_wr;
                        r_row_cnt <= r_row_cnt + 1'b1;
                        if (r_row_cnt == c_last_row) begin
                            r_state <= S_FINISH;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ROW_READY_out     = (r_state == S_DRAIN) && !STALL;
    assign OUT_SRAM_ADDR_out = r_addr;
    assign OUT_SRAM_WEn_out  = r_wen | STALL;
    assign OUT_SRAM_BE_out   = r_be;
    assign OUT_SRAM_D_out    = r_d;
    assign BUSY_out          = r_busy;
    assign DONE_out          = r_done & ~STALL;

endmodule
`default_nettype wire

// File: tb/tb_out_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_out_writeback
// Brief    : Self-checking bench for out_writeback: tile table plus scoreboard
//            of expected SRAM writes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_out_writeback;

    localparam int ACC   = 32;
    localparam int ROWS  = 32;
    localparam int COLS  = 32;
    localparam int AW    = 10;
    localparam int ROWW  = ACC*COLS;

    logic            CLK = 1'b0;
    logic            RSTn;
    logic            STALL;
    logic            FLUSH_START_in;
    logic [AW-1:0]   TILE_BASE_ADDR_in;
    logic [5:0]      VALID_ROWS_in;
    logic [5:0]      VALID_COLS_in;
    logic            ROW_VALID_in;
    logic [ROWW-1:0] ROW_DATA_in;
    logic            ROW_READY_out;
    logic [AW-1:0]   OUT_SRAM_ADDR_out;
    logic            OUT_SRAM_WEn_out;
    logic [ROWW-1:0] OUT_SRAM_BE_out;
    logic [ROWW-1:0] OUT_SRAM_D_out;
    logic            BUSY_out;
    logic            DONE_out;

    out_writeback dut (
        .CLK               (CLK),
        .RSTn              (RSTn),
        .STALL             (STALL),
        .FLUSH_START_in    (FLUSH_START_in),
        .TILE_BASE_ADDR_in (TILE_BASE_ADDR_in),
        .VALID_ROWS_in     (VALID_ROWS_in),
        .VALID_COLS_in     (VALID_COLS_in),
        .ROW_VALID_in      (ROW_VALID_in),
        .ROW_DATA_in       (ROW_DATA_in),
        .ROW_READY_out     (ROW_READY_out),
        .OUT_SRAM_ADDR_out (OUT_SRAM_ADDR_out),
        .OUT_SRAM_WEn_out  (OUT_SRAM_WEn_out),
        .OUT_SRAM_BE_out   (OUT_SRAM_BE_out),
        .OUT_SRAM_D_out    (OUT_SRAM_D_out),
        .BUSY_out          (BUSY_out),
        .DONE_out          (DONE_out)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [AW-1:0]   addr;
        logic [ROWW-1:0] be;
        logic [ROWW-1:0] d;
    } wr_t;

    typedef struct {
        logic [AW-1:0] base;
        logic [5:0]    rows;
        logic [5:0]    cols;
        int            stall_row;
        int            reset_row;
        bit            poke_start;
        bit            relu_pat;
        int            exp_writes;
    } tile_t;

    wr_t   exp_q[$];
    int    n_total  = 0;
    int    n_pass   = 0;
    int    n_writes = 0;
    bit    relu_chk = 1'b0;

`ifdef OUT_WRITEBACK_RELU_EN
    localparam logic [ACC-1:0] c_lane0_exp = 32'h0000_0000;
`else
    localparam logic [ACC-1:0] c_lane0_exp = 32'hFFFF_FFF6;
`endif

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic chk_wide(input string name, input logic [ROWW-1:0] act, input logic [ROWW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else begin
            for (int c = 0; c < COLS; c++) begin
                if (act[(COLS-1-c)*ACC +: ACC] !== exp[(COLS-1-c)*ACC +: ACC]) begin
                    $display("FAIL %s: column %0d got %0h, want %0h (t=%0t)", name, c,
                             act[(COLS-1-c)*ACC +: ACC], exp[(COLS-1-c)*ACC +: ACC], $time);
                    break;
                end
            end
        end
    endtask

    function automatic logic [ROWW-1:0] model_d(input logic [ROWW-1:0] x);
        logic [ROWW-1:0] y;
        y = x;
`ifdef OUT_WRITEBACK_RELU_EN
        for (int c = 0; c < COLS; c++)
            if (x[c*ACC + ACC - 1]) y[c*ACC +: ACC] = '0;
`endif
        return y;
    endfunction

    function automatic logic [ROWW-1:0] model_be(input int cols);
        logic [ROWW-1:0] m;
        m = '0;
        for (int c = 0; c < COLS; c++)
            if (c < cols) m[ROWW-1-c*ACC -: ACC] = '1;
        return m;
    endfunction

    // SRAM-side scoreboard: every presented write must match the oldest expected one.
    always @(negedge CLK) begin
        if (RSTn === 1'b1 && OUT_SRAM_WEn_out === 1'b0) begin
            wr_t e;
            n_writes++;
            n_total++;
            if (exp_q.size() > 0) begin
                n_pass++;
                e = exp_q.pop_front();
                chk("wr_addr", 64'(OUT_SRAM_ADDR_out), 64'(e.addr));
                chk_wide("wr_be", OUT_SRAM_BE_out, e.be);
                chk_wide("wr_data", OUT_SRAM_D_out, e.d);
                if (relu_chk) begin
                    chk("relu_lane0", 64'(OUT_SRAM_D_out[ROWW-1 -: ACC]), 64'(c_lane0_exp));
                    chk("relu_lane1", 64'(OUT_SRAM_D_out[ROWW-1-ACC -: ACC]), 64'h2A);
                end
            end else begin
                $display("FAIL unexpected_write: addr %0h presented, expected queue empty (t=%0t)",
                         OUT_SRAM_ADDR_out, $time);
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        chk({tag, "_addr"},  64'(OUT_SRAM_ADDR_out), 64'h0);
        chk({tag, "_wen"},   64'(OUT_SRAM_WEn_out),  64'h1);
        chk_wide({tag, "_be"}, OUT_SRAM_BE_out, '0);
        chk_wide({tag, "_d"},  OUT_SRAM_D_out,  '0);
        chk({tag, "_ready"}, 64'(ROW_READY_out), 64'h0);
        chk({tag, "_busy"},  64'(BUSY_out),      64'h0);
        chk({tag, "_done"},  64'(DONE_out),      64'h0);
    endtask

    task automatic run_tile(input tile_t t);
        int              vr;
        int              vc;
        bit              was_reset;
        logic [ROWW-1:0] data;
        wr_t             w;
        vr = (int'(t.rows) > ROWS) ? ROWS : int'(t.rows);
        vc = (int'(t.cols) > COLS) ? COLS : int'(t.cols);
        was_reset = 1'b0;
        n_writes  = 0;
        relu_chk  = t.relu_pat;

        @(posedge CLK); #1;
        FLUSH_START_in    = 1'b1;
        TILE_BASE_ADDR_in = t.base;
        VALID_ROWS_in     = t.rows;
        VALID_COLS_in     = t.cols;
        @(posedge CLK); #1;
        FLUSH_START_in    = 1'b0;
        TILE_BASE_ADDR_in = $urandom;
        VALID_ROWS_in     = '0;
        VALID_COLS_in     = '0;

        for (int r = 0; r < ROWS; r++) begin
            if (t.reset_row == r) begin
                RSTn = 1'b0;
                #1;
                check_reset_vals("midreset");
                exp_q.delete();
                ROW_VALID_in = 1'b0;
                @(negedge CLK);
                RSTn = 1'b1;
                was_reset = 1'b1;
                break;
            end
            for (int c = 0; c < COLS; c++) data[c*ACC +: ACC] = $urandom;
            if (t.relu_pat) begin
                data[ROWW-1 -: ACC]     = 32'hFFFF_FFF6;
                data[ROWW-1-ACC -: ACC] = 32'h0000_002A;
            end
            ROW_DATA_in  = data;
            ROW_VALID_in = 1'b1;
            if (r < vr) begin
                w.addr = t.base + AW'(r);
                w.be   = model_be(vc);
                w.d    = model_d(data);
                exp_q.push_back(w);
            end
            @(negedge CLK);
            chk("ready_drain", 64'(ROW_READY_out), 64'h1);
            chk("busy_drain",  64'(BUSY_out),      64'h1);
            @(posedge CLK); #1;
            if (t.stall_row == r) begin
                STALL = 1'b1;
                repeat (3) begin
                    @(negedge CLK);
                    chk("stall_wen",   64'(OUT_SRAM_WEn_out), 64'h1);
                    chk("stall_ready", 64'(ROW_READY_out),    64'h0);
                    chk("stall_done",  64'(DONE_out),         64'h0);
                    @(posedge CLK);
                end
                #1;
                STALL = 1'b0;
            end
        end
        ROW_VALID_in = 1'b0;

        if (!was_reset) begin
            @(negedge CLK);
            chk("finish_done", 64'(DONE_out), 64'h0);
            chk("finish_busy", 64'(BUSY_out), 64'h1);
            @(posedge CLK); #1;
            if (t.poke_start) begin
                FLUSH_START_in    = 1'b1;
                TILE_BASE_ADDR_in = 10'h155;
                VALID_ROWS_in     = 6'd32;
                VALID_COLS_in     = 6'd32;
            end
            @(negedge CLK);
            chk("done_pulse", 64'(DONE_out), 64'h1);
            chk("done_busy",  64'(BUSY_out), 64'h0);
            @(posedge CLK); #1;
            FLUSH_START_in = 1'b0;
            @(negedge CLK);
            chk("done_cleared", 64'(DONE_out),      64'h0);
            chk("idle_busy",    64'(BUSY_out),      64'h0);
            chk("idle_ready",   64'(ROW_READY_out), 64'h0);
            chk("queue_drained", 64'(exp_q.size()), 64'h0);
        end
        chk("write_count", 64'(n_writes), 64'(t.exp_writes));
        relu_chk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tile_t tiles[9];
        //           base     rows   cols  stall rst poke relu writes
        tiles[0] = '{10'h010, 6'd32, 6'd32, -1,  -1,  0,   0,  32};
        tiles[1] = '{10'h020, 6'd5,  6'd3,  -1,  -1,  0,   0,  5};
        tiles[2] = '{10'h3FE, 6'd4,  6'd32, -1,  -1,  1,   0,  4};
        tiles[3] = '{10'h100, 6'd32, 6'd32,  7,  -1,  0,   0,  32};
        tiles[4] = '{10'h200, 6'd32, 6'd32, -1,  12,  0,   0,  11};
        tiles[5] = '{10'h000, 6'd32, 6'd32, -1,  -1,  0,   1,  32};
        tiles[6] = '{10'h050, 6'd0,  6'd32, -1,  -1,  0,   0,  0};
        tiles[7] = '{10'h060, 6'd40, 6'd40, -1,  -1,  0,   0,  32};
        tiles[8] = '{10'h070, 6'd3,  6'd0,  -1,  -1,  0,   0,  3};

        RSTn              = 1'b0;
        STALL             = 1'b0;
        FLUSH_START_in    = 1'b0;
        TILE_BASE_ADDR_in = '0;
        VALID_ROWS_in     = '0;
        VALID_COLS_in     = '0;
        ROW_VALID_in      = 1'b0;
        ROW_DATA_in       = '0;
        repeat (3) @(negedge CLK);
        check_reset_vals("reset");
        RSTn = 1'b1;

        for (int i = 0; i < 9; i++) run_tile(tiles[i]);

        repeat (2) @(negedge CLK);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
